// File: rtl/cali_fac_bank_ctrl.sv
// cali_fac_bank_ctrl: double-buffered calibration factor bank with datapath-priority
// RAM arbitration, host shadow-bank access and frame-safe bank swap.
module cali_fac_bank_ctrl #(
  parameter int N_CH = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  dp_address,
  input  logic        dp_read,
  output logic [15:0] dp_cali_fac,
  output logic        dp_waitrequest,
  input  logic        frame_sop,
  input  logic        frame_eop,
  input  logic [9:0]  host_address,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [15:0] host_writedata,
  output logic [15:0] host_readdata,
  output logic        host_readdatavalid,
  output logic        host_waitrequest,
  output logic [9:0]  ram_address,
  output logic        ram_rden,
  output logic        ram_wren,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_q
);
  localparam logic [9:0] NCH = 10'(N_CH);
  typedef enum logic {DP_IDLE, DP_ACK} dp_state_e;
  dp_state_e   dp_state_q;
  logic        active_bank_q, commit_q, frame_active_q, rdv_q, rd_ram_q;
  logic [15:0] swap_cnt_q, rd_data_q, csr_rd;
  logic        swap, dp_issue, grant, is_csr, in_range, host_fac_rd, host_fac_wr, commit_wr;
  // Swap only between frames and only while the datapath is quiet.
  assign swap = !rst && commit_q && !frame_active_q && !frame_sop && dp_state_q == DP_IDLE && !dp_read;
  assign dp_issue = !rst && dp_state_q == DP_IDLE && dp_read;
  assign grant = !rst && (host_read || host_write) && !dp_issue && !swap;
  assign is_csr = host_address[9];
  assign in_range = {1'b0, host_address[8:0]} < NCH;
  assign host_fac_wr = grant && host_write && !is_csr && in_range;
  assign host_fac_rd = grant && !host_write && !is_csr && in_range;
  assign commit_wr = grant && host_write && is_csr && host_address[8:0] == 9'd0 && host_writedata[0];
  assign csr_rd = host_address[8:0] == 9'd0 ? {13'b0, frame_active_q, active_bank_q, commit_q} :
                  host_address[8:0] == 9'd1 ? swap_cnt_q : 16'h0;
  assign ram_rden = dp_issue || host_fac_rd;
  assign ram_wren = host_fac_wr;
  assign ram_wdata = host_fac_wr ? host_writedata : 16'h0;
  assign ram_address = dp_issue ? {active_bank_q, dp_address} :
                       (host_fac_rd || host_fac_wr) ? {~active_bank_q, host_address[8:0]} : 10'h0;
  assign dp_waitrequest = dp_state_q != DP_ACK;
  assign dp_cali_fac = dp_state_q == DP_ACK ? ram_q : 16'h0;
  assign host_waitrequest = !grant;
  assign host_readdatavalid = rdv_q;
  assign host_readdata = !rdv_q ? 16'h0 : rd_ram_q ? ram_q : rd_data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_state_q     <= DP_IDLE;
      active_bank_q  <= 1'b0;
      commit_q       <= 1'b0;
      frame_active_q <= 1'b0;
      swap_cnt_q     <= 16'h0;
      rdv_q          <= 1'b0;
      rd_ram_q       <= 1'b0;
      rd_data_q      <= 16'h0;
    end else begin
      dp_state_q     <= dp_issue ? DP_ACK : DP_IDLE;
      frame_active_q <= frame_sop || (frame_active_q && !frame_eop);
      active_bank_q  <= active_bank_q ^ swap;
      commit_q       <= !swap && (commit_q || commit_wr);
      swap_cnt_q     <= swap_cnt_q + 16'(swap);
      rdv_q          <= grant && !host_write;
      rd_ram_q       <= host_fac_rd;
      rd_data_q      <= is_csr ? csr_rd : 16'h0;
    end
  end
endmodule

// File: tb/tb_cali_fac_bank_ctrl.sv
// tb_cali_fac_bank_ctrl: randomized bench for the factor bank controller against a
// two-bank memory model plus explicit bank/commit/swap-count bookkeeping.
module tb_cali_fac_bank_ctrl;
  localparam int N_CH = 320;
  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  dp_address;
  logic        dp_read;
  logic [15:0] dp_cali_fac;
  logic        dp_waitrequest;
  logic        frame_sop, frame_eop;
  logic [9:0]  host_address;
  logic        host_read, host_write;
  logic [15:0] host_writedata, host_readdata;
  logic        host_readdatavalid, host_waitrequest;
  logic [9:0]  ram_address;
  logic        ram_rden, ram_wren;
  logic [15:0] ram_wdata, ram_q;
  logic [15:0] ram [1024] = '{default: 16'h0};
  logic [15:0] exp_mem [2][512] = '{default: '{default: 16'h0}};
  logic        exp_bank;
  int          exp_cnt;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  cali_fac_bank_ctrl #(.N_CH(N_CH)) dut (
    .clk(clk), .rst(rst),
    .dp_address(dp_address), .dp_read(dp_read), .dp_cali_fac(dp_cali_fac), .dp_waitrequest(dp_waitrequest),
    .frame_sop(frame_sop), .frame_eop(frame_eop),
    .host_address(host_address), .host_read(host_read), .host_write(host_write),
    .host_writedata(host_writedata), .host_readdata(host_readdata),
    .host_readdatavalid(host_readdatavalid), .host_waitrequest(host_waitrequest),
    .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) ram[ram_address] <= ram_wdata;
    if (ram_rden) ram_q <= ram[ram_address];
  end

  function automatic logic [15:0] ctrl_val(input logic c, input logic b, input logic f);
    return {13'b0, f, b, c};
  endfunction

  task automatic host_wr(input logic [9:0] a, input logic [15:0] d, output int nw);
    logic ok;
    ok = !a[9] && int'(a[8:0]) < N_CH;
    nw = 0;
    @(negedge clk); host_address = a; host_writedata = d; host_write = 1'b1; #1;
    while (host_waitrequest !== 1'b0 && nw < 20) begin @(negedge clk); #1; nw++; end
    checks++;
    if (host_waitrequest !== 1'b0) begin errors++; $display("FAIL host_wr_grant a=%h waitrequest=%b want 0", a, host_waitrequest); end
    checks++;
    if (ram_wren !== ok) begin errors++; $display("FAIL host_wr_wren a=%h got %b want %b", a, ram_wren, ok); end
    if (ok) begin
      checks++;
      if (ram_address !== {~exp_bank, a[8:0]} || ram_wdata !== d) begin
        errors++; $display("FAIL host_wr_ram got addr=%h data=%h want addr=%h data=%h", ram_address, ram_wdata, {~exp_bank, a[8:0]}, d);
      end
      exp_mem[~exp_bank][a[8:0]] = d;
    end
    @(posedge clk); #1; host_write = 1'b0;
  endtask

  task automatic host_rd(input logic [9:0] a, output logic [15:0] d, output int nw);
    nw = 0;
    @(negedge clk); host_address = a; host_read = 1'b1; #1;
    while (host_waitrequest !== 1'b0 && nw < 20) begin @(negedge clk); #1; nw++; end
    checks++;
    if (host_waitrequest !== 1'b0) begin errors++; $display("FAIL host_rd_grant a=%h waitrequest=%b want 0", a, host_waitrequest); end
    @(posedge clk); #1; host_read = 1'b0;
    checks++;
    if (host_readdatavalid !== 1'b1) begin errors++; $display("FAIL host_rd_valid a=%h got %b want 1", a, host_readdatavalid); end
    d = host_readdata;
  endtask

  task automatic dp_rd(input logic [8:0] a, output logic [15:0] d);
    int n = 0;
    @(negedge clk); dp_address = a; dp_read = 1'b1; #1;
    while (ram_rden !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (ram_rden !== 1'b1 || ram_address !== {exp_bank, a} || dp_waitrequest !== 1'b1) begin
      errors++; $display("FAIL dp_rd_issue rden=%b addr=%h wait=%b want 1 %h 1", ram_rden, ram_address, dp_waitrequest, {exp_bank, a});
    end
    @(posedge clk); #1; dp_read = 1'b0;
    checks++;
    if (dp_waitrequest !== 1'b0) begin errors++; $display("FAIL dp_rd_ack wait=%b want 0", dp_waitrequest); end
    d = dp_cali_fac;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s got %h want %h", name, got, want); end
  endtask

  task automatic test_reset;
    rst = 1'b1; dp_read = 1'b1; dp_address = 9'd5; host_read = 1'b1; host_write = 1'b1;
    host_address = 10'd3; host_writedata = 16'hffff; frame_sop = 1'b1; frame_eop = 1'b0;
    repeat (2) @(negedge clk); #1;
    chk("rst_dp_wait", 16'(dp_waitrequest), 16'd1);
    chk("rst_host_wait", 16'(host_waitrequest), 16'd1);
    chk("rst_dp_fac", dp_cali_fac, 16'h0);
    chk("rst_rdata", host_readdata, 16'h0);
    chk("rst_rdv", 16'(host_readdatavalid), 16'd0);
    chk("rst_rden", 16'(ram_rden), 16'd0);
    chk("rst_wren", 16'(ram_wren), 16'd0);
    chk("rst_addr", 16'(ram_address), 16'h0);
    chk("rst_wdata", ram_wdata, 16'h0);
    dp_read = 1'b0; host_read = 1'b0; host_write = 1'b0; frame_sop = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_bank = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_fill_commit;
    logic [15:0] d; int nw;
    for (int e = 0; e < N_CH; e++) host_wr(10'(e), 16'h2000, nw);
    host_wr(10'h200, 16'h0001, nw);
    host_rd(10'h200, d, nw);
    chk("commit_swap_wait", 16'(nw), 16'd1);
    exp_bank = ~exp_bank; exp_cnt++;
    chk("commit_ctrl", d, 16'h0002);
    host_rd(10'h201, d, nw);
    chk("commit_swapcnt", d, 16'(exp_cnt));
    host_rd(10'h202, d, nw);
    chk("csr_other", d, 16'h0);
    for (int i = 0; i < 4; i++) begin
      logic [8:0] a = 9'($urandom_range(0, N_CH - 1));
      dp_rd(a, d);
      chk("fill_dp", d, exp_mem[exp_bank][a]);
    end
  endtask

  task automatic test_dp_read;
    @(posedge clk); #1;
    @(negedge clk); dp_address = 9'd5; dp_read = 1'b1; #1;
    chk("dp5_issue", {14'b0, ram_rden, dp_waitrequest}, 16'b11);
    chk("dp5_addr", 16'(ram_address), 16'({exp_bank, 9'd5}));
    @(negedge clk); #1;
    chk("dp5_ack", {14'b0, ram_rden, dp_waitrequest}, 16'b00);
    chk("dp5_data", dp_cali_fac, exp_mem[exp_bank][5]);
    @(negedge clk); #1;
    chk("dp5_reissue", {14'b0, ram_rden, dp_waitrequest}, 16'b11);
    @(posedge clk); #1; dp_read = 1'b0;
  endtask

  task automatic test_random;
    logic [15:0] d; int nw;
    for (int i = 0; i < 60; i++) begin
      logic [8:0] a = 9'($urandom_range(0, N_CH - 1));
      case ($urandom_range(0, 2))
        0: host_wr({1'b0, a}, 16'($urandom), nw);
        1: begin host_rd({1'b0, a}, d, nw); chk("rand_host_rd", d, exp_mem[~exp_bank][a]); end
        default: begin a = 9'($urandom); dp_rd(a, d); chk("rand_dp_rd", d, exp_mem[exp_bank][a]); end
      endcase
    end
  endtask

  task automatic test_frame_commit;
    logic [15:0] d; int nw;
    @(negedge clk); frame_sop = 1'b1;
    @(posedge clk); #1; frame_sop = 1'b0;
    host_wr(10'h200, 16'h0001, nw);
    repeat (3) @(negedge clk);
    host_rd(10'h200, d, nw);
    chk("frame_ctrl_pending", d, ctrl_val(1'b1, exp_bank, 1'b1));
    for (int i = 0; i < 3; i++) begin
      logic [8:0] a = 9'($urandom_range(0, N_CH - 1));
      dp_rd(a, d); chk("frame_dp_oldbank", d, exp_mem[exp_bank][a]);
    end
    @(negedge clk); frame_eop = 1'b1; host_address = 10'h200; host_read = 1'b1; #1;
    chk("eop_grant", 16'(host_waitrequest), 16'd0);
    @(posedge clk); #1; frame_eop = 1'b0; host_read = 1'b0;
    chk("eop_ctrl", host_readdata, ctrl_val(1'b1, exp_bank, 1'b1));
    host_rd(10'h200, d, nw);
    chk("post_eop_swap_wait", 16'(nw), 16'd1);
    exp_bank = ~exp_bank; exp_cnt++;
    chk("post_eop_ctrl", d, ctrl_val(1'b0, exp_bank, 1'b0));
    // commit landing on the same cycle as sop must wait for that frame's eop
    @(negedge clk); frame_sop = 1'b1; host_address = 10'h200; host_writedata = 16'h0001; host_write = 1'b1; #1;
    chk("sop_commit_grant", 16'(host_waitrequest), 16'd0);
    @(posedge clk); #1; frame_sop = 1'b0; host_write = 1'b0;
    repeat (3) @(negedge clk);
    host_rd(10'h200, d, nw);
    chk("sop_commit_pending", d, ctrl_val(1'b1, exp_bank, 1'b1));
    dp_rd(9'd11, d); chk("sop_dp_oldbank", d, exp_mem[exp_bank][11]);
    @(negedge clk); frame_eop = 1'b1;
    @(posedge clk); #1; frame_eop = 1'b0;
    repeat (2) @(negedge clk);
    exp_bank = ~exp_bank; exp_cnt++;
    host_rd(10'h200, d, nw);
    chk("sop_commit_swapped", d, ctrl_val(1'b0, exp_bank, 1'b0));
    host_rd(10'h201, d, nw);
    chk("frame_swapcnt", d, 16'(exp_cnt));
  endtask

  task automatic test_contention;
    logic [15:0] d, w; int nw;
    w = 16'($urandom);
    @(posedge clk); #1;
    @(negedge clk); dp_address = 9'd7; dp_read = 1'b1; host_address = 10'd3; host_writedata = w; host_write = 1'b1; #1;
    chk("cont_dp_first", {13'b0, ram_rden, host_waitrequest, ram_wren}, 16'b110);
    @(posedge clk); #1; dp_read = 1'b0;
    @(negedge clk); #1;
    chk("cont_dp_ack", {14'b0, dp_waitrequest, host_waitrequest}, 16'b00);
    chk("cont_dp_data", dp_cali_fac, exp_mem[exp_bank][7]);
    chk("cont_host_wr", {5'b0, ram_wren, ram_address}, {5'b0, 1'b1, ~exp_bank, 9'd3});
    @(posedge clk); #1; host_write = 1'b0;
    exp_mem[~exp_bank][3] = w;
    host_rd(10'd3, d, nw);
    chk("cont_readback", d, w);
  endtask

  task automatic test_out_of_range;
    logic [15:0] d; int nw;
    host_wr(10'd400, 16'hbeef, nw);
    host_rd(10'd400, d, nw); chk("oor_400", d, 16'h0);
    host_wr(10'd319, 16'h1319, nw);
    host_wr(10'd320, 16'h1320, nw);
    host_rd(10'd320, d, nw); chk("oor_320", d, 16'h0);
    host_rd(10'd319, d, nw); chk("edge_319", d, 16'h1319);
    @(negedge clk); host_address = 10'h201; host_writedata = 16'h1234; host_read = 1'b1; host_write = 1'b1; #1;
    chk("rw_as_write_wait", 16'(host_waitrequest), 16'd0);
    @(posedge clk); #1; host_read = 1'b0; host_write = 1'b0;
    chk("rw_as_write_nordv", 16'(host_readdatavalid), 16'd0);
    host_rd(10'h201, d, nw); chk("swapcnt_ro", d, 16'(exp_cnt));
  endtask

  task automatic test_reset_mid;
    logic [15:0] d; int nw, n;
    @(negedge clk); frame_sop = 1'b1;
    @(posedge clk); #1; frame_sop = 1'b0;
    host_wr(10'h200, 16'h0001, nw);
    n = 0;
    @(negedge clk); host_address = 10'h200; host_read = 1'b1; #1;
    while (host_waitrequest !== 1'b0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("rstmid_grant", 16'(host_waitrequest), 16'd0);
    rst = 1'b1;
    @(posedge clk); #1; host_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_bank = 1'b0; exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid_no_rdv", 16'(host_readdatavalid), 16'd0);
    end
    host_rd(10'h200, d, nw); chk("rstmid_ctrl", d, 16'h0);
    host_rd(10'h201, d, nw); chk("rstmid_swapcnt", d, 16'h0);
    for (int i = 0; i < 4; i++) begin
      logic [8:0] a = 9'($urandom_range(0, N_CH - 1));
      dp_rd(a, d); chk("rstmid_ram_kept", d, exp_mem[0][a]);
    end
  endtask

  initial begin
    test_reset;
    test_fill_commit;
    test_dp_read;
    test_random;
    test_frame_commit;
    test_contention;
    test_out_of_range;
    test_random;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cali_fac_bank_ctrl.md
CALI_FAC_BANK_CTRL -- requirements
Module: cali_fac_bank_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 320, meaning the number of valid factor entries per bank.
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports dp_address in 9, dp_read in 1, dp_cali_fac out 16, dp_waitrequest out 1: the calibration-datapath factor read slave.
REQ-005 SHALL have ports frame_sop in 1 and frame_eop in 1: accepted start-of-frame and end-of-frame beat strobes.
REQ-006 SHALL have ports host_address in 10, host_read in 1, host_write in 1, host_writedata in 16, host_readdata out 16, host_readdatavalid out 1, host_waitrequest out 1: the host Avalon-MM slave.
REQ-007 SHALL have ports ram_address out 10, ram_rden out 1, ram_wren out 1, ram_wdata out 16, ram_q in 16: a single-port 1024x16 RAM with 1-cycle read latency.

Function
REQ-008 SHALL form ram_address as {bank, addr[8:0]}, with datapath accesses using active_bank and host accesses using ~active_bank (the shadow bank).
REQ-009 SHALL use a datapath FSM with states DP_IDLE and DP_ACK.
REQ-010 DP_IDLE with dp_read=1 and no swap this cycle SHALL issue ram_rden with {active_bank, dp_address} and go to DP_ACK.
REQ-011 DP_ACK SHALL drive dp_waitrequest=0 and dp_cali_fac=ram_q for exactly one cycle, then return to DP_IDLE; dp_waitrequest SHALL be 1 in all other cycles.
REQ-012 SHALL give the datapath priority: a host access is granted only in a cycle with no datapath issue and no swap; the DP_ACK cycle SHALL count as free for the host.
REQ-013 A granted host access SHALL drive host_waitrequest=0 in that cycle; host_waitrequest SHALL be 1 whenever host_read or host_write is pending and not granted.
REQ-014 host_address[9]=0 SHALL select factor entry host_address[8:0] in the shadow bank.
REQ-015 A granted write to an entry < N_CH SHALL assert ram_wren with ram_wdata=host_writedata; a write to an entry >= N_CH SHALL be acknowledged and discarded.
REQ-016 A granted factor read SHALL assert host_readdatavalid exactly one cycle after the grant, with host_readdata=ram_q, or 0 for an entry >= N_CH.
REQ-017 host_address[9]=1 SHALL select CSRs: offset 0 CTRL, offset 1 SWAP_COUNT, other offsets read 0 and ignore writes; CSR reads SHALL return data with host_readdatavalid one cycle after the grant.
REQ-018 CTRL writes: bit0=1 SHALL set commit_pending. CTRL reads: bit0=commit_pending, bit1=active_bank, bit2=frame_active, other bits 0.
REQ-019 frame_active SHALL set on frame_sop and clear on frame_eop; if both occur in one cycle, it SHALL end set.
REQ-020 A swap SHALL occur in a cycle where commit_pending=1, frame_active=0, frame_sop=0 and the DP FSM is in DP_IDLE with dp_read=0.
REQ-021 A swap SHALL toggle active_bank, clear commit_pending, increment SWAP_COUNT (16-bit, wrapping FFFF->0) and hold host_waitrequest=1 that cycle.
REQ-022 A commit written while frame_active=1 SHALL be deferred until after that frame's frame_eop; a commit coinciding with frame_sop SHALL wait for that frame's end, so the frame uses the old bank.
REQ-023 A host CTRL commit write SHALL set commit_pending no earlier than the next cycle, so the swap occurs at the earliest one cycle after the write.
REQ-024 Simultaneous host_read and host_write SHALL be treated as a write.

Reset
REQ-025 rst SHALL force the following: active_bank=0, commit_pending=0, frame_active=0, SWAP_COUNT=0, DP FSM=DP_IDLE.
REQ-026 rst SHALL force outputs dp_waitrequest=1, host_waitrequest=1, dp_cali_fac=0, host_readdata=0, host_readdatavalid=0, ram_rden=0, ram_wren=0, ram_address=0, ram_wdata=0.
REQ-027 A reset asserted mid-frame or mid-transaction SHALL abandon it; no pending readdatavalid SHALL be emitted after reset release, and RAM contents are not cleared.

Verification
REQ-028 Host writes 0x2000 to entries 0..319 while idle, commits -> next-cycle swap; CTRL reads 0x0002; SWAP_COUNT=1.
REQ-029 dp_read with dp_address=5 held -> ram_rden in cycle N, dp_waitrequest=0 with dp_cali_fac=RAM[{active,5}] in cycle N+1 only.
REQ-030 Commit during active frame -> CTRL bit0 stays 1 through frame_eop; swap occurs the cycle after frame_eop; datapath reads inside the frame return old-bank values.
REQ-031 host_write and dp_read asserted in the same DP_IDLE cycle -> datapath issued, host_waitrequest=1; host granted in the DP_ACK cycle.
REQ-032 Write to entry 400, then read entry 400 -> no ram_wren; readdatavalid with 0x0000.
REQ-033 rst pulse after a granted host read, before readdatavalid -> no readdatavalid; CTRL reads 0x0000.
